pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
- Owns the architectural fetch PC register for the pipelined miniLA core and decides each cycle whether the PC holds, advances by 4, or takes a redirect target.
- Redirect targets come from the next-PC logic after a branch or jump resolves in EX.
- Arbitrates between EX redirects, ID load-use stalls, global freezes (memory wait/debug) and instruction-fetch acceptance.
- Buffers one redirect across a freeze, generates IF/ID and ID/EX flush pulses, and keeps saturating performance counters.

Parameters:
- RESET_PC, 32'h1C00_0000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  EX has resolved a taken branch or jump this cycle.
- redirect_target  in  32  next-PC target from the next-PC logic.
- stall  in  1  load-use hazard; hold PC and IF/ID.
- freeze  in  1  global pipeline freeze; nothing in the pipe advances.
- fetch_gnt  in  1  instruction memory accepts the current fetch_req/pc.
- pc  out  32  current fetch PC.
- fetch_req  out  1  a fetch request is presented at pc.
- flush_if_id  out  1  squash the IF/ID register this cycle.
- flush_id_ex  out  1  squash the ID/EX register this cycle.
- pc_misalign  out  1  the applied redirect target had nonzero bits [1:0].
- redirect_cnt  out  CNT_W  number of applied redirects, saturating.
- stall_cnt  out  CNT_W  number of stall cycles, saturating.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - pc=RESET_PC, state=BOOT, pend_target=0, both counters=0.
  - A pending redirect is discarded.
  - Comb outputs fetch_req, flush_if_id, flush_id_ex, pc_misalign are 0 while in BOOT.
- States: BOOT, RUN, FROZEN, REDIR_PEND.
- BOOT: no inputs are observed. Go to RUN unconditionally after 1 cycle, so the first fetch_req is in the 2nd cycle after rst drops.
- RUN, priority high to low:
  1. freeze=1 and redirect_valid=1: pend_target<=redirect_target, go to REDIR_PEND. pc holds, no flush.
  2. freeze=1: go to FROZEN, pc holds.
  3. redirect_valid=1 (apply redirect):
     - pc<=redirect_target with bits [1:0] forced to 2'b00.
     - flush_if_id=flush_id_ex=1 in the same cycle (combinational).
     - pc_misalign=|redirect_target[1:0] in that cycle.
     - redirect_cnt+1. Stay in RUN.
     - A redirect overrides a simultaneous stall; stall_cnt is not incremented.
  4. stall=1: pc holds, stall_cnt+1.
  5. fetch_gnt=1: pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC goes to 0).
  6. Otherwise pc holds.
- FROZEN:
  - pc holds.
  - redirect_valid=1: latch pend_target, go to REDIR_PEND. This wins over freeze=0 in the same cycle.
  - freeze=0 with no redirect: go to RUN.
- REDIR_PEND:
  - pc holds; redirect_valid is ignored (the pipeline is frozen, so this is the same branch).
  - freeze=0: apply pend_target exactly as in RUN step 3, including flush pulses, pc_misalign and the count, then go to RUN.
  - pend_target is never overwritten while pending.
- fetch_req = (state==RUN) & ~freeze & ~stall & ~redirect_valid. It is 0 during BOOT, FROZEN, REDIR_PEND and redirect cycles.
- Flush outputs are asserted only on an apply cycle, and for exactly 1 cycle per applied redirect.
- Counters saturate at all-ones and never wrap.
- The next-state logic is purely synchronous. Outputs other than pc and the counters are combinational from state and inputs.

Test Plan:
- Reset/boot: rst high for 2 cycles, then low, fetch_gnt=1 → pc=32'h1C000000 with fetch_req=0 for one cycle; then fetch_req=1 and pc=1C000004, 1C000008 on successive cycles.
- Stall: stall=1 for 3 cycles at pc=1C000010 → pc stays 1C000010, fetch_req=0, stall_cnt=3; resume at 1C000014.
- Redirect with simultaneous stall: redirect_target=32'h1C000100 with stall=1 → flush_if_id=flush_id_ex=1 for 1 cycle, next pc=1C000100, redirect_cnt=1, stall_cnt unchanged. With target 1C000102 → pc=1C000100 and pc_misalign=1.
- Redirect during freeze:
  - freeze=1 plus redirect to 1C000200, then 4 frozen cycles with redirect_valid toggling to 1C000300 → pc held, no flush.
  - Freeze drops → flush pulse, next pc=1C000200 (not 1C000300).
- Reset while in REDIR_PEND → pc=RESET_PC, no flush pulse, counters 0, pending target lost.
- Saturation/wrap:
  - With CNT_W=4, 20 stall cycles → stall_cnt=4'hF.
  - Redirect to FFFFFFFC followed by a grant → pc=0.

Source files
------------

// File: rtl/pc_flow_ctrl.sv
// Fetch PC owner for the miniLA pipeline: hold / +4 / redirect arbitration,
// one-deep redirect buffering across freezes, flush pulses and perf counters.
module pc_flow_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             stall,
  input  logic             freeze,
  input  logic             fetch_gnt,
  output logic [31:0]      pc,
  output logic             fetch_req,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_misalign,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    FROZEN     = 2'd2,
    REDIR_PEND = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_target, pend_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] apply_target;
  logic        apply;
  logic        stall_inc;

  // State, PC, pending target and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pend_target  <= 32'h0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_target <= pend_nxt;
      if (apply && (redirect_cnt != {CNT_W{1'b1}}))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Next-state / PC arbitration; an apply cycle may come from RUN or REDIR_PEND
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend_target;
    pc_nxt       = pc;
    apply        = 1'b0;
    apply_target = redirect_target;
    stall_inc    = 1'b0;
    fetch_req    = 1'b0;

    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        fetch_req = ~freeze & ~stall & ~redirect_valid;
        if (freeze && redirect_valid) begin
          pend_nxt  = redirect_target;
          state_nxt = REDIR_PEND;
        end else if (freeze) begin
          state_nxt = FROZEN;
        end else if (redirect_valid) begin
          apply = 1'b1;
        end else if (stall) begin
          stall_inc = 1'b1;
        end else if (fetch_gnt) begin
          pc_nxt = pc + 32'd4;
        end
      end
      FROZEN: begin
        if (redirect_valid) begin
          pend_nxt  = redirect_target;
          state_nxt = REDIR_PEND;
        end else if (!freeze) begin
          state_nxt = RUN;
        end
      end
      REDIR_PEND: begin
        // Redirects seen while pending are the same branch re-presented
        if (!freeze) begin
          apply        = 1'b1;
          apply_target = pend_target;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase

    if (apply)
      pc_nxt = {apply_target[31:2], 2'b00};

    flush_if_id = apply;
    flush_id_ex = apply;
    pc_misalign = apply & (|apply_target[1:0]);
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl; a CNT_W=4 twin shares stimulus for saturation.
module tb_pc_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        freeze;
  logic        fetch_gnt;

  logic [31:0] pc, pc4;
  logic        fetch_req, fetch_req4;
  logic        flush_if_id, flush_if_id4;
  logic        flush_id_ex, flush_id_ex4;
  logic        pc_misalign, pc_misalign4;
  logic [15:0] redirect_cnt, stall_cnt;
  logic [3:0]  redirect_cnt4, stall_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_flow_ctrl u_dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall), .freeze(freeze),
    .fetch_gnt(fetch_gnt), .pc(pc), .fetch_req(fetch_req),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .pc_misalign(pc_misalign), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  pc_flow_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall), .freeze(freeze),
    .fetch_gnt(fetch_gnt), .pc(pc4), .fetch_req(fetch_req4),
    .flush_if_id(flush_if_id4), .flush_id_ex(flush_id_ex4),
    .pc_misalign(pc_misalign4), .redirect_cnt(redirect_cnt4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flush(input string tag, input logic exp);
    #1;
    chk({tag, "_fifd"}, 32'(flush_if_id), 32'(exp));
    chk({tag, "_fide"}, 32'(flush_id_ex), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    stall = 1'b0; freeze = 1'b0; fetch_gnt = 1'b1;

    // Reset and boot
    tick(); tick();
    chk("rst_pc", pc, 32'h1C00_0000);
    chk("rst_rcnt", 32'(redirect_cnt), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0; #1;
    chk("boot_req", 32'(fetch_req), 32'd0);
    chk_flush("boot", 1'b0);
    tick();
    chk("run_pc0", pc, 32'h1C00_0000);
    chk("run_req", 32'(fetch_req), 32'd1);
    tick();
    chk("run_pc1", pc, 32'h1C00_0004);
    tick();
    chk("run_pc2", pc, 32'h1C00_0008);
    tick(); tick();
    chk("run_pc4", pc, 32'h1C00_0010);

    // Load-use stall for 3 cycles
    stall = 1'b1; #1;
    chk("stall_req", 32'(fetch_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h1C00_0010);
    end
    chk("stall_cnt3", 32'(stall_cnt), 32'd3);
    stall = 1'b0;
    tick();
    chk("stall_resume", pc, 32'h1C00_0014);

    // Redirect overrides simultaneous stall
    redirect_valid = 1'b1; redirect_target = 32'h1C00_0100; stall = 1'b1;
    chk_flush("redir", 1'b1);
    chk("redir_mis", 32'(pc_misalign), 32'd0);
    chk("redir_req", 32'(fetch_req), 32'd0);
    tick();
    redirect_valid = 1'b0; stall = 1'b0; fetch_gnt = 1'b0;
    chk("redir_pc", pc, 32'h1C00_0100);
    chk("redir_rcnt", 32'(redirect_cnt), 32'd1);
    chk("redir_scnt", 32'(stall_cnt), 32'd3);
    chk_flush("redir_after", 1'b0);
    tick();
    chk("nognt_pc", pc, 32'h1C00_0100);

    // Misaligned target gets bits [1:0] cleared
    redirect_valid = 1'b1; redirect_target = 32'h1C00_0102; #1;
    chk("mis_flag", 32'(pc_misalign), 32'd1);
    tick();
    redirect_valid = 1'b0;
    chk("mis_pc", pc, 32'h1C00_0100);
    chk("mis_rcnt", 32'(redirect_cnt), 32'd2);

    // Redirect during freeze is buffered; later redirects ignored
    freeze = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1C00_0200;
    chk_flush("frz_redir", 1'b0);
    chk("frz_req", 32'(fetch_req), 32'd0);
    tick();
    redirect_target = 32'h1C00_0300;
    for (int i = 0; i < 4; i++) begin
      redirect_valid = (i % 2 == 0);
      chk_flush("pend", 1'b0);
      tick();
      chk("pend_pc", pc, 32'h1C00_0100);
    end
    freeze = 1'b0; redirect_valid = 1'b0;
    chk_flush("pend_apply", 1'b1);
    chk("pend_mis", 32'(pc_misalign), 32'd0);
    tick();
    chk("pend_pc_out", pc, 32'h1C00_0200);
    chk("pend_rcnt", 32'(redirect_cnt), 32'd3);
    chk_flush("pend_after", 1'b0);

    // FROZEN: redirect wins over freeze release in the same cycle
    freeze = 1'b1; tick();
    freeze = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h1C00_0400;
    chk_flush("frozen_redir", 1'b0);
    tick();
    redirect_valid = 1'b0;
    chk("frozen_hold", pc, 32'h1C00_0200);
    chk_flush("frozen_apply", 1'b1);
    tick();
    chk("frozen_pc", pc, 32'h1C00_0400);
    chk("frozen_rcnt", 32'(redirect_cnt), 32'd4);

    // Reset while a redirect is pending
    freeze = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1C00_0500;
    tick();
    redirect_valid = 1'b0; rst = 1'b1;
    tick();
    chk("prst_pc", pc, 32'h1C00_0000);
    chk("prst_rcnt", 32'(redirect_cnt), 32'd0);
    chk("prst_scnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0; freeze = 1'b0;
    chk_flush("prst_boot", 1'b0);
    tick();
    chk_flush("prst_run", 1'b0);
    tick();
    chk("prst_pc2", pc, 32'h1C00_0000);

    // Counter saturation
    stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    stall = 1'b0;
    chk("sat_scnt4", 32'(stall_cnt4), 32'h0000_000F);
    chk("sat_scnt16", 32'(stall_cnt), 32'd20);

    // PC wrap
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; fetch_gnt = 1'b1;
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_pc4", pc4, 32'h0000_0000);
    chk("wrap_rcnt4", 32'(redirect_cnt4), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
